// File: rtl/hyper_pkg.sv
// Shared types for the HyperBus CK-enable sequencer: phase/state encodings
// and the fixed command/address length.
package hyper_pkg;

  localparam int CA_CYCLES = 3;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_CA   = 2'd1,
    PH_LAT  = 2'd2,
    PH_DATA = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CA    = 3'd2,
    ST_LAT   = 3'd3,
    ST_DATA  = 3'd4,
    ST_HOLD  = 3'd5
  } state_e;

  // SETUP and HOLD report as the idle/CS phase
  function automatic phase_e phase_of(input state_e st);
    case (st)
      ST_CA:   return PH_CA;
      ST_LAT:  return PH_LAT;
      ST_DATA: return PH_DATA;
      default: return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/hyper_cycle_cnt.sv
// Loadable down-counter with enable and zero flag; a phase lasts load value + 1
// enabled cycles, ending on the cycle the zero flag is seen.
module hyper_cycle_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_r;

  // load has priority over counting; counting saturates at zero
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_r <= '0;
    end else if (load_i) begin
      cnt_r <= load_val_i;
    end else if (en_i && (cnt_r != '0)) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero_o = (cnt_r == '0);

endmodule

// File: rtl/hyper_ck_en_ctrl.sv
// Per-transaction HyperBus CK-enable sequencer: CS setup, CA, latency, data burst
// and CS hold, with all outputs registered from the next state.
module hyper_ck_en_ctrl
  import hyper_pkg::*;
#(
  parameter int LAT_W    = 5,
  parameter int LEN_W    = 16,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             trans_valid_i,
  output logic             trans_ready_o,
  input  logic [LEN_W-1:0] trans_len_i,
  input  logic [LAT_W-1:0] trans_lat_i,
  input  logic             trans_lat2x_i,
  input  logic             data_ready_i,
  input  logic             abort_i,
  output logic             ck_en_o,
  output logic             cs_no,
  output logic [1:0]       phase_o,
  output logic             data_beat_o,
  output logic             done_o,
  output logic             aborted_o
);

  localparam int CNT_W = (LEN_W > LAT_W + 1) ? LEN_W : LAT_W + 1;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] CA_LD    = CNT_W'(CA_CYCLES - 1);

  state_e           state_r, state_s;
  logic [LEN_W-1:0] len_r;
  logic [LAT_W:0]   lat_r;
  logic             abort_flag_r;
  logic             cnt_load_s, cnt_en_s, cnt_zero_s, accept_s, abort_take_s;
  logic [CNT_W-1:0] cnt_val_s, lat_ld_s, len_ld_s;
  logic             ck_en_s, beat_s, done_s;

  assign lat_ld_s = CNT_W'(lat_r) - CNT_W'(1);
  assign len_ld_s = CNT_W'(len_r) - CNT_W'(1);

  hyper_cycle_cnt #(.W(CNT_W)) u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_val_s),
    .en_i       (cnt_en_s),
    .zero_o     (cnt_zero_s)
  );

  // next-state and phase counter control
  always_comb begin
    state_s      = state_r;
    cnt_load_s   = 1'b0;
    cnt_val_s    = '0;
    cnt_en_s     = 1'b0;
    accept_s     = 1'b0;
    abort_take_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (trans_valid_i) begin
          state_s    = ST_SETUP;
          cnt_load_s = 1'b1;
          cnt_val_s  = SETUP_LD;
          accept_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP, ST_CA, ST_LAT: begin
        if (abort_i) begin
          state_s      = ST_HOLD;
          cnt_load_s   = 1'b1;
          cnt_val_s    = HOLD_LD;
          abort_take_s = 1'b1;
        end else if (!cnt_zero_s) begin
          cnt_en_s = 1'b1;
        end else if (state_r == ST_SETUP) begin
          state_s    = ST_CA;
          cnt_load_s = 1'b1;
          cnt_val_s  = CA_LD;
        end else if ((state_r == ST_CA) && (lat_r != '0)) begin
          state_s    = ST_LAT;
          cnt_load_s = 1'b1;
          cnt_val_s  = lat_ld_s;
        end else if (len_r != '0) begin
          state_s    = ST_DATA;
          cnt_load_s = 1'b1;
          cnt_val_s  = len_ld_s;
        end else begin
          state_s    = ST_HOLD;
          cnt_load_s = 1'b1;
          cnt_val_s  = HOLD_LD;
        end
      end
      ST_DATA: begin
        // a final beat wins over a simultaneous abort
        if (data_beat_o && cnt_zero_s) begin
          state_s    = ST_HOLD;
          cnt_load_s = 1'b1;
          cnt_val_s  = HOLD_LD;
        end else if (abort_i) begin
          state_s      = ST_HOLD;
          cnt_load_s   = 1'b1;
          cnt_val_s    = HOLD_LD;
          abort_take_s = 1'b1;
        end else begin
          cnt_en_s = data_beat_o;
        end
      end
      ST_HOLD: begin
        if (cnt_zero_s) begin
          state_s = ST_IDLE;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign ck_en_s = (state_s == ST_CA) || (state_s == ST_LAT) ||
                   ((state_s == ST_DATA) && data_ready_i);
  assign beat_s  = (state_s == ST_DATA) && data_ready_i;
  assign done_s  = (state_r == ST_HOLD) && (state_s == ST_IDLE);

  // state, captured request and abort tracking
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      len_r        <= '0;
      lat_r        <= '0;
      abort_flag_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        len_r        <= trans_len_i;
        lat_r        <= trans_lat2x_i ? {trans_lat_i, 1'b0} : {1'b0, trans_lat_i};
        abort_flag_r <= 1'b0;
      end else if (abort_take_s) begin
        abort_flag_r <= 1'b1;
      end else begin
        abort_flag_r <= abort_flag_r;
      end
    end
  end

  // registered outputs, derived from the next state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ck_en_o       <= 1'b0;
      cs_no         <= 1'b1;
      phase_o       <= PH_IDLE;
      data_beat_o   <= 1'b0;
      done_o        <= 1'b0;
      aborted_o     <= 1'b0;
      trans_ready_o <= 1'b1;
    end else begin
      ck_en_o       <= ck_en_s;
      cs_no         <= (state_s == ST_IDLE);
      phase_o       <= phase_of(state_s);
      data_beat_o   <= beat_s;
      done_o        <= done_s;
      aborted_o     <= done_s && abort_flag_r;
      trans_ready_o <= (state_s == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_hyper_ck_en_ctrl.sv
// Directed bench for hyper_ck_en_ctrl: runs whole transactions and compares
// CS/CK/beat/done statistics against hand-computed values.
module tb_hyper_ck_en_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        trans_valid_i = 1'b0;
  logic        trans_ready_o;
  logic [15:0] trans_len_i = 16'd0;
  logic [4:0]  trans_lat_i = 5'd0;
  logic        trans_lat2x_i = 1'b0;
  logic        data_ready_i = 1'b1;
  logic        abort_i = 1'b0;
  logic        ck_en_o, cs_no, data_beat_o, done_o, aborted_o;
  logic [1:0]  phase_o;

  int n_checks = 0;
  int n_fail   = 0;

  int cs_cnt, ck_cnt, ck_runs, beats, max_ph, ab_seen, first_ck, tmo;

  hyper_ck_en_ctrl #(.LAT_W(5), .LEN_W(16), .CS_SETUP(1), .CS_HOLD(1)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .trans_valid_i (trans_valid_i),
    .trans_ready_o (trans_ready_o),
    .trans_len_i   (trans_len_i),
    .trans_lat_i   (trans_lat_i),
    .trans_lat2x_i (trans_lat2x_i),
    .data_ready_i  (data_ready_i),
    .abort_i       (abort_i),
    .ck_en_o       (ck_en_o),
    .cs_no         (cs_no),
    .phase_o       (phase_o),
    .data_beat_o   (data_beat_o),
    .done_o        (done_o),
    .aborted_o     (aborted_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issues one request and observes it until done_o (index 0 = first cycle after accept).
  task automatic run_txn(input int len, input int lat, input int lat2x,
                         input int stall_at, input int stall_n, input int abort_idx);
    int idx, stall_left, prev_ck;
    bit done, stalled;
    check("ready_before_accept", int'(trans_ready_o), 1);
    trans_valid_i = 1'b1;
    trans_len_i   = 16'(len);
    trans_lat_i   = 5'(lat);
    trans_lat2x_i = lat2x[0];
    step();
    trans_valid_i = 1'b0;
    trans_len_i   = 16'd0;
    trans_lat_i   = 5'd0;
    cs_cnt = 0; ck_cnt = 0; ck_runs = 0; beats = 0; max_ph = 0; ab_seen = 0;
    first_ck = -1; idx = 0; stall_left = 0; prev_ck = 0; done = 1'b0; stalled = 1'b0;
    while (!done && idx < 200) begin
      if (!cs_no) cs_cnt++;
      if (ck_en_o) begin
        ck_cnt++;
        if (prev_ck == 0) ck_runs++;
        if (first_ck < 0) first_ck = idx;
      end
      prev_ck = int'(ck_en_o);
      if (data_beat_o) beats++;
      if (int'(phase_o) > max_ph) max_ph = int'(phase_o);
      if (done_o) begin
        done = 1'b1;
        ab_seen = int'(aborted_o);
      end
      if (beats == stall_at && !stalled) begin
        data_ready_i = 1'b0;
        stalled = 1'b1;
        stall_left = stall_n;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) data_ready_i = 1'b1;
      end
      abort_i = (idx == abort_idx);
      if (!done) begin
        step();
        idx++;
      end
    end
    abort_i = 1'b0;
    data_ready_i = 1'b1;
    tmo = done ? 0 : 1;
  endtask

  initial begin
    // 1. reset
    rst_ni = 1'b0;
    step();
    step();
    check("rst_ck_en", int'(ck_en_o), 0);
    check("rst_cs_n", int'(cs_no), 1);
    check("rst_ready", int'(trans_ready_o), 1);
    check("rst_done", int'(done_o), 0);
    check("rst_phase", int'(phase_o), 0);
    rst_ni = 1'b1;
    step();

    // 2. len=4 lat=6
    run_txn(4, 6, 0, -1, 0, -1);
    check("t2_timeout", tmo, 0);
    check("t2_cs_low", cs_cnt, 15);
    check("t2_ck_high", ck_cnt, 13);
    check("t2_ck_runs", ck_runs, 1);
    check("t2_first_ck", first_ck, 1);
    check("t2_beats", beats, 4);
    check("t2_aborted", ab_seen, 0);
    check("t2_max_phase", max_ph, 3);

    // 3. back-to-back, len=2 lat=6 doubled
    run_txn(2, 6, 1, -1, 0, -1);
    check("t3_timeout", tmo, 0);
    check("t3_cs_low", cs_cnt, 19);
    check("t3_ck_high", ck_cnt, 17);
    check("t3_beats", beats, 2);

    // 4. CA only
    run_txn(0, 0, 0, -1, 0, -1);
    check("t4_timeout", tmo, 0);
    check("t4_cs_low", cs_cnt, 5);
    check("t4_ck_high", ck_cnt, 3);
    check("t4_max_phase", max_ph, 1);
    check("t4_beats", beats, 0);

    // 5. stall of 2 cycles after beat 2
    run_txn(4, 2, 0, 2, 2, -1);
    check("t5_timeout", tmo, 0);
    check("t5_cs_low", cs_cnt, 13);
    check("t5_ck_high", ck_cnt, 9);
    check("t5_ck_runs", ck_runs, 2);
    check("t5_beats", beats, 4);

    // 6. abort in 3rd LAT cycle (index 6)
    run_txn(4, 6, 0, -1, 0, 6);
    check("t6_timeout", tmo, 0);
    check("t6_cs_low", cs_cnt, 8);
    check("t6_ck_high", ck_cnt, 6);
    check("t6_beats", beats, 0);
    check("t6_aborted", ab_seen, 1);
    step();
    check("t6_done_one_cycle", int'(done_o), 0);

    // 6b. reset during CA of next request
    trans_valid_i = 1'b1;
    trans_len_i = 16'd4;
    trans_lat_i = 5'd6;
    step();
    trans_valid_i = 1'b0;
    step();
    check("t6b_in_ca", int'(phase_o), 1);
    check("t6b_ck_in_ca", int'(ck_en_o), 1);
    rst_ni = 1'b0;
    step();
    check("t6b_rst_cs_n", int'(cs_no), 1);
    check("t6b_rst_ck_en", int'(ck_en_o), 0);
    check("t6b_rst_phase", int'(phase_o), 0);
    check("t6b_rst_ready", int'(trans_ready_o), 1);
    check("t6b_rst_done", int'(done_o), 0);
    rst_ni = 1'b1;
    step();

    // recovery after mid-transaction reset
    run_txn(0, 0, 0, -1, 0, -1);
    check("t7_timeout", tmo, 0);
    check("t7_ck_high", ck_cnt, 3);
    check("t7_cs_low", cs_cnt, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
